// File: rtl/mcs_led_pkg.sv
// Shared encodings for the MCS LED controller: channel modes, register offsets, CHn field positions.
// Latency: none (constants and a pure helper function only).
// Backpressure: not applicable.
package mcs_led_pkg;

    typedef enum logic [1:0] {
        MODE_STEADY = 2'd0,
        MODE_PWM    = 2'd1,
        MODE_BLINK  = 2'd2,
        MODE_OFF    = 2'd3
    } led_mode_t;

    // Byte offsets of the register map; the bus decodes word addresses.
    localparam logic [7:0] REG_CTRL    = 8'h00;
    localparam logic [7:0] REG_RAW     = 8'h04;
    localparam logic [7:0] REG_CH_BASE = 8'h08;

    // Field positions inside CTRL and CHn.
    localparam int CTRL_EN_BIT  = 0;
    localparam int CH_MODE_LSB  = 0;
    localparam int CH_MODE_W    = 2;
    localparam int CH_DUTY_LSB  = 8;
    localparam int CH_HALF_LSB  = 16;

    // Word index of a byte offset (address bits [1:0] are not decoded).
    function automatic int unsigned word_index(input logic [7:0] byte_off);
        return int'(byte_off) >> 2;
    endfunction

endpackage

// File: rtl/mcs_led_ctrl_if.sv
// MicroBlaze MCS IO bus bundle between the bus master and the LED controller.
// Latency: wires only; the slave answers with io_ready one cycle after io_addr_strobe.
// Backpressure: none; every strobe is accepted and completed by exactly one io_ready.
interface mcs_led_ctrl_if #(
    parameter int ADDR_W = 8
);
    logic              io_addr_strobe;
    logic              io_write_strobe;
    logic              io_read_strobe;
    logic [ADDR_W-1:0] io_address;
    logic [31:0]       io_write_data;
    logic [31:0]       io_read_data;
    logic              io_ready;

    modport master (
        output io_addr_strobe,
        output io_write_strobe,
        output io_read_strobe,
        output io_address,
        output io_write_data,
        input  io_read_data,
        input  io_ready
    );

    modport slave (
        input  io_addr_strobe,
        input  io_write_strobe,
        input  io_read_strobe,
        input  io_address,
        input  io_write_data,
        output io_read_data,
        output io_ready
    );

endinterface

// File: rtl/mcs_led_channel.sv
// One LED channel: config register, blink counter/state, mode mux and registered LED output.
// Latency: led follows its source (RAW bit, PWM compare, blink state, enable) by one cycle.
// Backpressure: none; config writes land on the edge that ends the strobe cycle.
module mcs_led_channel
    import mcs_led_pkg::*;
#(
    parameter int PWM_W   = 8,
    parameter int BLINK_W = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic             frame,
    input  logic [PWM_W-1:0] pwm_cnt,
    input  logic             raw_bit,
    input  logic             wr_en,
    input  logic [31:0]      wr_data,
    output logic [31:0]      cfg_rdata,
    output logic             led
);

    led_mode_t          mode_q;
    logic [PWM_W-1:0]   duty_q;
    logic [BLINK_W-1:0] half_q;
    logic [BLINK_W-1:0] blink_cnt;
    logic               blink_state;
    logic [BLINK_W-1:0] blink_last;
    logic               pwm_on;
    logic               chan_out;
    logic               led_q;

    // Channel configuration register, loaded by a bus write to this CHn word.
    always_ff @(posedge clk) begin
        if (reset) begin
            mode_q <= MODE_STEADY;
            duty_q <= '0;
            half_q <= '0;
        end else if (wr_en) begin
            mode_q <= led_mode_t'(wr_data[CH_MODE_LSB +: CH_MODE_W]);
            duty_q <= wr_data[CH_DUTY_LSB +: PWM_W];
            half_q <= wr_data[CH_HALF_LSB +: BLINK_W];
        end
    end

    // Terminal blink count (a half-period of 0 behaves like 1) and the duty compare.
    always_comb begin
        blink_last = '0;
        if (half_q != '0) begin
            blink_last = half_q - BLINK_W'(1);
        end
        pwm_on = (pwm_cnt < duty_q);
    end

    // Blink timebase: any config write (which is also the only way to enter or leave
    // BLINK) or a disabled controller restarts it; otherwise it advances once per frame.
    always_ff @(posedge clk) begin
        if (reset) begin
            blink_cnt   <= '0;
            blink_state <= 1'b0;
        end else if (wr_en || !en) begin
            blink_cnt   <= '0;
            blink_state <= 1'b0;
        end else if (frame && (mode_q == MODE_BLINK)) begin
            if (blink_cnt == blink_last) begin
                blink_cnt   <= '0;
                blink_state <= ~blink_state;
            end else begin
                blink_cnt <= blink_cnt + BLINK_W'(1);
            end
        end
    end

    // Mode mux; a disabled controller forces the channel dark.
    always_comb begin
        chan_out = 1'b0;
        if (en) begin
            unique case (mode_q)
                MODE_STEADY: chan_out = raw_bit;
                MODE_PWM:    chan_out = pwm_on;
                MODE_BLINK:  chan_out = blink_state & pwm_on;
                MODE_OFF:    chan_out = 1'b0;
                default:     chan_out = 1'b0;
            endcase
        end
    end

    // Output flop driving the pin.
    always_ff @(posedge clk) begin
        if (reset) begin
            led_q <= 1'b0;
        end else begin
            led_q <= chan_out;
        end
    end

    // Read-back image of the config word; unused bits read as zero.
    always_comb begin
        cfg_rdata = '0;
        cfg_rdata[CH_MODE_LSB +: CH_MODE_W] = mode_q;
        cfg_rdata[CH_DUTY_LSB +: PWM_W]     = duty_q;
        cfg_rdata[CH_HALF_LSB +: BLINK_W]   = half_q;
    end

    assign led = led_q;

endmodule

// File: rtl/mcs_led_ctrl.sv
// MCS IO-bus LED controller: bus decode, CTRL/RAW registers, prescaler, PWM counter, NUM_LEDS channels.
// Latency: io_ready one cycle after io_addr_strobe; led follows a register write one cycle after io_ready.
// Backpressure: none; every strobe (mapped or not) completes with a single io_ready pulse.
module mcs_led_ctrl
    import mcs_led_pkg::*;
#(
    parameter int NUM_LEDS = 8,
    parameter int PWM_W    = 8,
    parameter int PRESCALE = 125,
    parameter int BLINK_W  = 16,
    parameter int ADDR_W   = 8
) (
    input  logic                clk,
    input  logic                reset,
    mcs_led_ctrl_if.slave       bus,
    output logic [NUM_LEDS-1:0] led
);

    localparam int PRE_W = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam int unsigned CTRL_IDX    = word_index(REG_CTRL);
    localparam int unsigned RAW_IDX     = word_index(REG_RAW);
    localparam int unsigned CH_BASE_IDX = word_index(REG_CH_BASE);

    logic                en_q;
    logic [NUM_LEDS-1:0] raw_q;
    logic [PRE_W-1:0]    pre_cnt;
    logic [PWM_W-1:0]    pwm_cnt;
    logic                tick;
    logic                frame;

    int unsigned         widx;
    logic                do_write;
    logic                do_read;
    logic                sel_ctrl;
    logic                sel_raw;
    logic [NUM_LEDS-1:0] sel_ch;
    logic [31:0]         ch_rdata [NUM_LEDS];
    logic [31:0]         rdata_mux;

    logic                ready_q;
    logic [31:0]         rdata_q;

    // Address decode and read mux; a write qualifier suppresses read data.
    always_comb begin
        widx     = 32'(bus.io_address[ADDR_W-1:2]);
        do_write = bus.io_addr_strobe & bus.io_write_strobe;
        do_read  = bus.io_addr_strobe & bus.io_read_strobe & ~bus.io_write_strobe;
        sel_ctrl = (widx == CTRL_IDX);
        sel_raw  = (widx == RAW_IDX);
        sel_ch   = '0;
        for (int i = 0; i < NUM_LEDS; i++) begin
            sel_ch[i] = (widx == CH_BASE_IDX + unsigned'(i));
        end
        rdata_mux = '0;
        if (sel_ctrl) begin
            rdata_mux[CTRL_EN_BIT] = en_q;
        end
        if (sel_raw) begin
            rdata_mux[NUM_LEDS-1:0] = raw_q;
        end
        for (int i = 0; i < NUM_LEDS; i++) begin
            if (sel_ch[i]) begin
                rdata_mux = ch_rdata[i];
            end
        end
    end

    // Access completion: every strobe earns one io_ready; unmapped reads return zero.
    always_ff @(posedge clk) begin
        if (reset) begin
            ready_q <= 1'b0;
            rdata_q <= '0;
        end else begin
            ready_q <= bus.io_addr_strobe;
            rdata_q <= do_read ? rdata_mux : '0;
        end
    end

    // CTRL and RAW registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            en_q  <= 1'b0;
            raw_q <= '0;
        end else begin
            if (do_write && sel_ctrl) begin
                en_q <= bus.io_write_data[CTRL_EN_BIT];
            end
            if (do_write && sel_raw) begin
                raw_q <= bus.io_write_data[NUM_LEDS-1:0];
            end
        end
    end

    // Tick on the last prescaler count; a frame is the tick on which the PWM counter wraps.
    always_comb begin
        tick  = en_q && (pre_cnt == PRE_W'(PRESCALE - 1));
        frame = tick && (pwm_cnt == '1);
    end

    // Shared timebase, held at zero while the controller is disabled.
    always_ff @(posedge clk) begin
        if (reset || !en_q) begin
            pre_cnt <= '0;
            pwm_cnt <= '0;
        end else begin
            if (tick) begin
                pre_cnt <= '0;
                pwm_cnt <= pwm_cnt + PWM_W'(1);
            end else begin
                pre_cnt <= pre_cnt + PRE_W'(1);
            end
        end
    end

    for (genvar g = 0; g < NUM_LEDS; g++) begin : g_ch
        mcs_led_channel #(
            .PWM_W   (PWM_W),
            .BLINK_W (BLINK_W)
        ) u_ch (
            .clk       (clk),
            .reset     (reset),
            .en        (en_q),
            .frame     (frame),
            .pwm_cnt   (pwm_cnt),
            .raw_bit   (raw_q[g]),
            .wr_en     (do_write & sel_ch[g]),
            .wr_data   (bus.io_write_data),
            .cfg_rdata (ch_rdata[g]),
            .led       (led[g])
        );
    end

    assign bus.io_ready     = ready_q;
    assign bus.io_read_data = rdata_q;

endmodule

// File: tb/tb_mcs_led_ctrl.sv
module tb_mcs_led_ctrl;

    localparam int N          = 8;
    localparam int PW         = 8;
    localparam int P          = 4;
    localparam int BW         = 16;
    localparam int AW         = 8;
    localparam int FRAME_CLKS = P * 256;

    logic         clk = 1'b0;
    logic         reset = 1'b1;
    logic [N-1:0] led;

    mcs_led_ctrl_if #(.ADDR_W(AW)) bus_if ();

    mcs_led_ctrl #(
        .NUM_LEDS (N),
        .PWM_W    (PW),
        .PRESCALE (P),
        .BLINK_W  (BW),
        .ADDR_W   (AW)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus_if),
        .led   (led)
    );

    always #5 clk = ~clk;

    int vectors     = 0;
    int miscompares = 0;
    int cyc         = 0;

    // Reference state in terms of the register map and elapsed enabled time.
    bit         m_en;
    bit [N-1:0] m_raw;
    int         m_mode [N];
    int         m_duty [N];
    int         m_half [N];
    int         m_fclr [N];   // frame number at which the channel's blink last restarted
    int         m_k;          // clock edges since the controller became enabled
    bit [N-1:0] m_led;
    bit [N-1:0] m_next;

    typedef struct {
        int        due;
        bit [31:0] data;
    } exp_t;
    exp_t sb [$];

    function automatic int pwm_val(input int k);
        return (k / P) % 256;
    endfunction

    function automatic int frames(input int k);
        return k / FRAME_CLKS;
    endfunction

    function automatic bit chan(input int i);
        int hp;
        bit on;
        bit bs;
        if (!m_en) return 1'b0;
        on = (pwm_val(m_k) < m_duty[i]);
        hp = (m_half[i] == 0) ? 1 : m_half[i];
        bs = (((frames(m_k) - m_fclr[i]) / hp) % 2) == 1;
        case (m_mode[i])
            0:       return m_raw[i];
            1:       return on;
            2:       return bs && on;
            default: return 1'b0;
        endcase
    endfunction

    function automatic bit [31:0] reg_read(input int idx);
        if (idx == 0) return {31'b0, m_en};
        if (idx == 1) return 32'(m_raw);
        if (idx >= 2 && idx < 2 + N)
            return {16'(m_half[idx-2]), 8'(m_duty[idx-2]), 6'b0, 2'(m_mode[idx-2])};
        return 32'h0;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s cyc %0d: got 0x%0h, expected 0x%0h", name, cyc, act, exp);
        end
    endtask

    // Reference model: advances on every clock edge from the inputs the DUT samples there.
    always @(posedge clk) begin
        bit        old_en;
        int        idx;
        bit [31:0] wd;
        exp_t      e;
        cyc++;
        if (reset) begin
            m_en = 1'b0; m_raw = '0; m_k = 0; m_led = '0; m_next = '0;
            for (int i = 0; i < N; i++) begin
                m_mode[i] = 0; m_duty[i] = 0; m_half[i] = 0; m_fclr[i] = 0;
            end
            sb.delete();
        end else begin
            m_led  = m_next;
            old_en = m_en;
            idx    = int'(bus_if.io_address[AW-1:2]);
            wd     = bus_if.io_write_data;
            if (bus_if.io_addr_strobe) begin
                e.due  = cyc;
                e.data = (bus_if.io_read_strobe && !bus_if.io_write_strobe) ? reg_read(idx) : 32'h0;
                sb.push_back(e);
            end
            m_k = old_en ? m_k + 1 : 0;
            if (!old_en) begin
                for (int i = 0; i < N; i++) m_fclr[i] = 0;
            end
            if (bus_if.io_addr_strobe && bus_if.io_write_strobe) begin
                if (idx == 0) m_en = wd[0];
                else if (idx == 1) m_raw = wd[N-1:0];
                else if (idx >= 2 && idx < 2 + N) begin
                    m_mode[idx-2] = int'(wd[1:0]);
                    m_duty[idx-2] = int'(wd[15:8]);
                    m_half[idx-2] = int'(wd[31:16]);
                    m_fclr[idx-2] = frames(m_k);
                end
            end
            for (int i = 0; i < N; i++) m_next[i] = chan(i);
        end
    end

    // Monitor: compares LEDs every cycle and pops the scoreboard when a completion is due.
    always @(posedge clk) begin
        exp_t e;
        bit   exp_rdy;
        #1;
        check("led", 32'(led), 32'(m_led));
        exp_rdy = (sb.size() > 0) && (sb[0].due == cyc);
        check("io_ready", {31'b0, bus_if.io_ready}, {31'b0, exp_rdy});
        if (exp_rdy) begin
            e = sb.pop_front();
            if (bus_if.io_ready) check("io_read_data", bus_if.io_read_data, e.data);
        end else begin
            check("idle_read_data", bus_if.io_read_data, 32'h0);
        end
    end

    task automatic drive(input logic [7:0] a, input logic [31:0] d, input bit r, input bit w);
        @(negedge clk);
        bus_if.io_addr_strobe  = 1'b1;
        bus_if.io_read_strobe  = r;
        bus_if.io_write_strobe = w;
        bus_if.io_address      = a;
        bus_if.io_write_data   = d;
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(negedge clk);
            bus_if.io_addr_strobe  = 1'b0;
            bus_if.io_read_strobe  = 1'b0;
            bus_if.io_write_strobe = 1'b0;
        end
    endtask

    task automatic wr(input logic [7:0] a, input logic [31:0] d);
        drive(a, d, 1'b0, 1'b1);
        idle(1);
    endtask

    task automatic rd(input logic [7:0] a);
        drive(a, 32'h0, 1'b1, 1'b0);
        idle(1);
    endtask

    initial begin
        int        w;
        logic [31:0] d;
        bit        r;
        bit        wf;
        bus_if.io_addr_strobe  = 1'b0;
        bus_if.io_read_strobe  = 1'b0;
        bus_if.io_write_strobe = 1'b0;
        bus_if.io_address      = '0;
        bus_if.io_write_data   = '0;
        reset = 1'b1;
        repeat (3) @(negedge clk);
        reset = 1'b0;

        // Reset values read back.
        rd(8'h00); rd(8'h04); rd(8'h08); idle(2);

        // Steady mode through RAW, then global disable.
        wr(8'h00, 32'h1); wr(8'h04, 32'hA5); idle(5);
        wr(8'h00, 32'h0); idle(4);

        // PWM on CH0 with duty 0x40, 0x00, 0xFF.
        wr(8'h00, 32'h1);
        wr(8'h08, {16'h0, 8'h40, 8'h01}); idle(2 * FRAME_CLKS);
        wr(8'h08, {16'h0, 8'h00, 8'h01}); idle(FRAME_CLKS + 10);
        wr(8'h08, {16'h0, 8'hFF, 8'h01}); idle(FRAME_CLKS + 10);

        // BLINK on CH1, half-period 2, rewritten mid-period.
        wr(8'h0C, {16'd2, 8'hFF, 8'h02}); idle(3 * FRAME_CLKS - 100);
        wr(8'h0C, {16'd2, 8'hFF, 8'h02}); idle(5 * FRAME_CLKS);
        rd(8'h0C);

        // Unmapped read, simultaneous read+write, back-to-back reads.
        rd(8'hFC);
        drive(8'h04, 32'h3C, 1'b1, 1'b1); idle(1);
        rd(8'h04);
        drive(8'h00, 32'h0, 1'b1, 1'b0);
        drive(8'h04, 32'h0, 1'b1, 1'b0);
        drive(8'h08, 32'h0, 1'b1, 1'b0);
        idle(2);

        // Randomised accesses.
        for (int n = 0; n < 60; n++) begin
            w  = $urandom_range(0, 11);
            r  = $urandom_range(0, 1) == 1;
            wf = $urandom_range(0, 2) != 0;
            if (w == 0)      d = ($urandom_range(0, 3) != 0) ? 32'h1 : 32'h0;
            else if (w >= 2) d = {16'($urandom_range(0, 3)), 8'($urandom), 6'($urandom), 2'($urandom)};
            else             d = $urandom;
            if (w == 11) w = 63;
            drive(8'(w * 4), d, r, wf);
            if ($urandom_range(0, 3) == 0) begin
                drive(8'($urandom_range(0, 9) * 4), 32'h0, 1'b1, 1'b0);
            end
            idle($urandom_range(1, 150));
        end

        // Reset while PWM runs and an access is being strobed.
        wr(8'h00, 32'h1);
        wr(8'h08, {16'h0, 8'h80, 8'h01});
        idle(300);
        @(negedge clk);
        reset = 1'b1;
        bus_if.io_addr_strobe = 1'b1;
        bus_if.io_read_strobe = 1'b1;
        bus_if.io_address     = 8'h04;
        @(negedge clk);
        reset = 1'b0;
        bus_if.io_addr_strobe = 1'b0;
        bus_if.io_read_strobe = 1'b0;
        idle(5);
        rd(8'h00); rd(8'h04); rd(8'h08);
        idle(5);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
